muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide unit with its own sequencing FSM for the single-cycle MIPS core.
//  Executes MULT/MULTU/DIV/DIVU one bit per cycle and owns the HI/LO register pair.
//  Raises busy so the main controller stalls the PC on MFHI/MFLO until results are valid.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH bits each, iteration count = WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  start        in   1      launch op; sampled only in IDLE
//  op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a            in   WIDTH  rs operand (multiplicand / dividend)
//  b            in   WIDTH  rt operand (multiplier / divisor)
//  busy         out  1      high whenever state != IDLE
//  done         out  1      one-cycle pulse; HI/LO valid from this cycle
//  div_by_zero  out  1      one-cycle pulse with done when DIV/DIVU has b==0
//  hi           out  WIDTH  HI register
//  lo           out  WIDTH  LO register
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=IDLE, hi=lo=0, busy=done=div_by_zero=0, counter=0.
//   Reset mid-operation aborts the op; hi/lo are cleared, with no done pulse.
//  FSM states: IDLE, RUN, FIN.
//   IDLE: start=1 -> latch op, |a|, |b| (abs only for signed ops) and result signs.
//     The divide path with b==0 goes to FIN; all other cases go to RUN with cnt=0.
//   RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle.
//     cnt increments each step; after step WIDTH-1 (cnt==WIDTH-1) -> FIN.
//   FIN: apply sign correction, write hi/lo, assert done for 1 cycle -> IDLE.
//  Latency: start at edge N -> done high in cycle N+WIDTH+1 (33 cycles for WIDTH=32).
//   Div-by-zero: done in cycle N+1.
//  Only hi/lo are architectural; internal accumulators never appear on the outputs before FIN.
//  start while busy=1 is ignored (no queueing). start in the same cycle as FIN's done is ignored;
//   the earliest relaunch is the following cycle, in IDLE.
//  Multiply: {hi,lo} = full 2*WIDTH product.
//   MULT negates the unsigned magnitude product when sign(a)^sign(b).
//  Divide: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
//   DIVU is unsigned. DIV -2^(W-1) / -1: lo=0x80000000, hi=0 (wraps, no trap).
//  Div by zero: hi/lo unchanged, done=1 and div_by_zero=1 for one cycle.
//  Magnitude of -2^(W-1) is handled as unsigned 2^(W-1), so one extra bit is never required.
//  hi/lo hold their value between operations; they change only in FIN or on reset.
//  No combinational path from start/a/b to any output; all outputs are registered or state-decoded.
// TESTING
//  MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at +33 cycles, hi=0xFFFFFFFE, lo=0x00000001.
//  MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles before done.
//  DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//  DIVU a=100 b=7 -> lo=14, hi=2.
//  DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  DIVU a=5 b=0 with prior hi=lo=0x1234 -> done+div_by_zero at +1 cycle; hi=lo=0x1234 unchanged.
//  Second start while busy -> ignored, result matches first op only.
//  rst at cycle 10 of a MULT -> busy=0, hi=lo=0 next cycle, no done pulse.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;       // sign of product (mult) or quotient (div)
    logic             neg_r;       // sign of remainder = sign of dividend
    logic [WIDTH-1:0] opnd;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi;      // partial product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;      // multiplier bits / dividend bits shifting into quotient
    logic             dbz;

    // Operand conditioning for launch: magnitudes only for signed ops.
    logic             signed_op;
    logic             sa, sb;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero_launch;

    // One iteration of shift-add / restoring shift-subtract, plus sign fix-up.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    // Launch-time operand magnitudes and result signs
    always_comb begin
        signed_op       = ~op[0];
        sa              = signed_op & a[WIDTH-1];
        sb              = signed_op & b[WIDTH-1];
        a_mag           = sa ? (~a + 1'b1) : a;
        b_mag           = sb ? (~b + 1'b1) : b;
        div_zero_launch = op[1] && (b == '0);
    end

    // Single datapath step and final sign correction of the step result
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod_fix = neg_q ? (~{step_hi, step_lo} + 1'b1) : {step_hi, step_lo};
        if (is_div) begin
            fin_lo = neg_q ? (~step_lo + 1'b1) : step_lo;
            fin_hi = neg_r ? (~step_hi + 1'b1) : step_hi;
        end else begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = div_zero_launch ? FIN : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_STEP) begin
                    state_nx = FIN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, datapath and HI/LO registers; HI/LO written on the last step so they are valid with done
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            dbz    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nx;
            dbz   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        opnd   <= op[1] ? b_mag : a_mag;
                        acc_hi <= '0;
                        acc_lo <= op[1] ? a_mag : b_mag;
                        cnt    <= '0;
                        dbz    <= div_zero_launch;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        hi <= fin_hi;
                        lo <= fin_lo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decoded from registered state
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == FIN);
        div_by_zero = dbz;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
        logic        exp_dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: architectural result computed with 64-bit integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic dz);
        longint          sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        dz = 1'b0;
        case (o)
            2'b00: begin sp = sx * sy; ref_hi = sp[63:32]; ref_lo = sp[31:0]; end
            2'b01: begin up = ux * uy; ref_hi = up[63:32]; ref_lo = up[31:0]; end
            2'b10: begin
                if (y == 0) dz = 1'b1;
                else begin sq = sx / sy; sr = sx % sy; ref_lo = sq[31:0]; ref_hi = sr[31:0]; end
            end
            default: begin
                if (y == 0) dz = 1'b1;
                else begin up = ux / uy; ref_lo = up[31:0]; up = ux % uy; ref_hi = up[31:0]; end
            end
        endcase
    endtask

    // Launch one op and wait (bounded) for done; latency counts edges from the launch edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int busy_cnt, output logic got_dbz);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        lat = 1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got_dbz = div_by_zero;
    endtask

    vec_t vecs[$];

    initial begin
        int   lat, bcnt, dcount;
        logic gdz, edz;

        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0});
        vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0});
        vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0});
        vecs.push_back('{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0});
        vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0});
        vecs.push_back('{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0});
        vecs.push_back('{2'b11, 32'h02469234, 32'h00002000, 32'h00001234, 32'h00001234, 33, 1'b0});
        vecs.push_back('{2'b11, 32'd5,        32'd0,        32'h00001234, 32'h00001234, 1,  1'b1});

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_dbz", {63'b0, div_by_zero}, 64'd0);
        check("reset_hi", {32'b0, hi}, 64'd0);
        check("reset_lo", {32'b0, lo}, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, gdz);
            check($sformatf("vec%0d_hi", i), {32'b0, hi}, {32'b0, vecs[i].exp_hi});
            check($sformatf("vec%0d_lo", i), {32'b0, lo}, {32'b0, vecs[i].exp_lo});
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].exp_lat - 1));
            check($sformatf("vec%0d_dbz", i), {63'b0, gdz}, {63'b0, vecs[i].exp_dbz});
            ref_hi = vecs[i].exp_hi;
            ref_lo = vecs[i].exp_lo;
        end

        // done and div_by_zero are single-cycle pulses
        @(posedge clk); @(negedge clk);
        check("pulse_done_low", {63'b0, done}, 64'd0);
        check("pulse_dbz_low", {63'b0, div_by_zero}, 64'd0);
        check("pulse_busy_low", {63'b0, busy}, 64'd0);

        for (int k = 0; k < 40; k++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          sel;
            ro  = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 20));
            model(ro, ra, rb, edz);
            run_op(ro, ra, rb, lat, bcnt, gdz);
            check($sformatf("rnd%0d_hi op=%0d a=%h b=%h", k, ro, ra, rb), {32'b0, hi}, {32'b0, ref_hi});
            check($sformatf("rnd%0d_lo op=%0d a=%h b=%h", k, ro, ra, rb), {32'b0, lo}, {32'b0, ref_lo});
            check($sformatf("rnd%0d_lat", k), 64'(lat), edz ? 64'd1 : 64'd33);
            check($sformatf("rnd%0d_dbz", k), {63'b0, gdz}, {63'b0, edz});
        end

        // start while busy is ignored; start during done is ignored too
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
        check("busy_ignore_done_seen", {63'b0, done}, 64'd1);
        check("busy_ignore_lo", {32'b0, lo}, 64'd15);
        check("busy_ignore_hi", {32'b0, hi}, 64'd0);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("fin_start_ignored_busy", {63'b0, busy}, 64'd0);
        check("fin_start_ignored_lo", {32'b0, lo}, 64'd15);

        // reset in the middle of a MULT aborts it with no done pulse
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'hFFFFFFFD; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("midop_busy_before_rst", {63'b0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midop_rst_busy", {63'b0, busy}, 64'd0);
        check("midop_rst_hi", {32'b0, hi}, 64'd0);
        check("midop_rst_lo", {32'b0, lo}, 64'd0);
        check("midop_rst_done", {63'b0, done}, 64'd0);
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("midop_no_late_done", 64'(dcount), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
